interval_capture: RTL and testbench
===================================

# interval_capture

Timestamp consumer that sits directly downstream of the 64-bit free-running cycle counter in the OpenCL timer library. It samples the counter on START/STOP/LAP commands from the kernel and computes elapsed cycle counts modulo 2^64. Results are buffered in a 4-entry FIFO and returned through the standard OpenCL HDL-library valid/ready handshake.

## Interface
- DEPTH, 4: result FIFO entries; must be a power of two, at least 2.
- clock  in  1  single clock domain; all logic is rising-edge.
- reset  in  1  synchronous, active-high; clears all state.
- counter  in  64  live counter value from the upstream cycle counter, sampled when a command is accepted.
- ivalid  in  1  command valid from kernel.
- cmd  in  2  0=START, 1=STOP, 2=LAP, 3=CLEAR.
- oready  out  1  block can accept a command this cycle.
- ovalid  out  1  FIFO head holds a valid result.
- iready  in  1  downstream ready to take the result.
- elapsed  out  64  FIFO head: elapsed cycles.
- running  out  1  state == RUNNING.

## Operation
- Command acceptance: `acc = ivalid & oready`. Only accepted commands act.
- `oready = !full`. This holds regardless of cmd, including START and CLEAR.
- States:
  - IDLE is the reset state.
  - RUNNING holds a 64-bit start register `t0`.
- IDLE transitions:
  - START: `t0 <= counter`, go to RUNNING.
  - STOP or LAP: accepted but no effect; nothing is pushed.
  - CLEAR: flush the FIFO.
- RUNNING transitions:
  - START: restart; `t0 <= counter`, stay in RUNNING, nothing is pushed.
  - STOP: push `counter - t0`, go to IDLE.
  - LAP: push `counter - t0` and set `t0 <= counter`; stay in RUNNING.
  - CLEAR: flush the FIFO, go to IDLE.
- Arithmetic: 64-bit unsigned subtraction, result truncated to 64 bits. Counter wrap-around therefore still yields the correct delta. No saturation.
- FIFO:
  - Push on an accepted STOP or LAP in RUNNING.
  - Pop when `ovalid & iready`.
  - `elapsed` shows the head entry. When empty, `elapsed` holds its last value; it is don't-care to the consumer.
- Push and pop in the same cycle:
  - Nonempty FIFO: occupancy unchanged.
  - Empty FIFO: not possible, since a push lands the following cycle.
- CLEAR has priority over any pop in the same cycle. After CLEAR the FIFO is empty, including entries whose pop coincided with the CLEAR.

## Timing
- Reset values:
  - state=IDLE, running=0, t0=0.
  - FIFO empty, so ovalid=0.
  - oready=1, elapsed=0.
- A command accepted in cycle N uses `counter` as sampled in cycle N.
- The result is visible at `elapsed` with ovalid=1 from cycle N+1 when the FIFO was empty (1-cycle latency). Otherwise it queues behind earlier entries.
- `running` updates in cycle N+1.
- oready is registered from occupancy:
  - It deasserts the cycle after the FIFO reaches DEPTH entries.
  - It reasserts the cycle after a pop from full.
  - A pop in the same cycle does not enable a push while full.
- ovalid stays high and `elapsed` stays stable while `ovalid & !iready`.
- Reset asserted mid-operation: the next cycle equals the reset state. In-flight results are discarded; t0 is cleared.

## Test plan
- Reset, then START at counter=100, STOP at counter=350, iready=1 -> one cycle later ovalid=1, elapsed=250, running=0; the next cycle ovalid=0.
- START at 1000, then LAP at 1010, LAP at 1025, STOP at 1100, with iready=1 -> results 10, 15, 75 in order; running goes 1→0 only after STOP.
- Wrap: START at 0xFFFF_FFFF_FFFF_FFF0, STOP at 0x10 -> elapsed=0x20.
- Backpressure: iready=0, START, then 5 LAPs, one per cycle -> 4 results queued; oready=0 after the 4th push; the 5th LAP is not accepted. Set iready=1 -> 4 results drain in order, oready returns to 1.
- STOP in IDLE -> no push, ovalid stays 0. Two STARTs at counter=10 and counter=40, then STOP at 50 -> elapsed=10.
- With 2 results queued and RUNNING, CLEAR with iready=1 -> next cycle ovalid=0, running=0. Apply reset mid-run -> all outputs return to reset values.

Source files
------------

// File: rtl/interval_capture.sv
// Interval timer: samples the free-running cycle counter on START/STOP/LAP
// commands and queues 64-bit elapsed deltas in a small result FIFO.
module interval_capture #(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] counter,
   input  logic        ivalid,
   input  logic [1:0]  cmd,
   output logic        oready,
   output logic        ovalid,
   input  logic        iready,
   output logic [63:0] elapsed,
   output logic        running
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

   typedef enum logic [1:0] {
      CMD_START = 2'd0,
      CMD_STOP  = 2'd1,
      CMD_LAP   = 2'd2,
      CMD_CLEAR = 2'd3
   } cmd_e;

   typedef enum logic {
      IDLE    = 1'b0,
      RUNNING = 1'b1
   } state_e;

   state_e        state;
   state_e        state_next;
   cmd_e          cmd_in;

   logic [63:0]   t0;
   logic [63:0]   delta;
   logic [63:0]   mem [DEPTH];
   logic [63:0]   last_head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          acc;
   logic          full;
   logic          empty;
   logic          do_push;
   logic          do_pop;
   logic          do_flush;
   logic          load_t0;

   assign cmd_in = cmd_e'(cmd);
   assign full   = (count == CNT_FULL);
   assign empty  = (count == '0);
   assign oready = !full;
   assign ovalid = !empty;
   assign acc    = ivalid & oready;
   assign delta  = counter - t0;
   // A CLEAR in the same cycle wins over the consumer's pop.
   assign do_pop = ovalid & iready & !do_flush;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (acc) begin
         unique case (state)
            IDLE: begin
               if (cmd_in == CMD_START) begin
                  state_next = RUNNING;
               end
            end
            RUNNING: begin
               if ((cmd_in == CMD_STOP) || (cmd_in == CMD_CLEAR)) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      running  = (state == RUNNING);
      do_push  = 1'b0;
      load_t0  = 1'b0;
      do_flush = 1'b0;
      if (acc) begin
         unique case (cmd_in)
            CMD_START: load_t0 = 1'b1;
            CMD_STOP:  do_push = running;
            CMD_LAP: begin
               do_push = running;
               load_t0 = running;
            end
            CMD_CLEAR: do_flush = 1'b1;
            default: begin
               do_push  = 1'b0;
               load_t0  = 1'b0;
               do_flush = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         t0 <= '0;
      end else if (load_t0) begin
         t0 <= counter;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= delta;
      end
   end

   // last_head keeps elapsed steady once the FIFO drains to empty.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_head <= '0;
      end else if (do_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            last_head <= mem[rd_ptr];
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign elapsed = empty ? last_head : mem[rd_ptr];

endmodule

// File: tb/tb_interval_capture.sv
// Directed bench for interval_capture with a queue scoreboard of expected
// deltas, filled as commands are issued and drained as results are popped.
module tb_interval_capture;

   localparam int DEPTH = 4;
   localparam logic [1:0] START = 2'd0;
   localparam logic [1:0] STOP  = 2'd1;
   localparam logic [1:0] LAP   = 2'd2;
   localparam logic [1:0] CLEAR = 2'd3;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] counter;
   logic        ivalid;
   logic [1:0]  cmd;
   logic        oready;
   logic        ovalid;
   logic        iready;
   logic [63:0] elapsed;
   logic        running;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] sb [$];
   logic        m_run;
   logic [63:0] m_t0;
   bit          mon_en = 1'b0;

   always #5 clock = ~clock;

   interval_capture #(.DEPTH(DEPTH)) dut (
      .clock   (clock),
      .reset   (reset),
      .counter (counter),
      .ivalid  (ivalid),
      .cmd     (cmd),
      .oready  (oready),
      .ovalid  (ovalid),
      .iready  (iready),
      .elapsed (elapsed),
      .running (running)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor runs on the falling edge, where inputs for the next rising edge are settled.
   task automatic tick();
      logic [63:0] exp_head;
      @(negedge clock);
      if (mon_en) begin
         checkOutput("ovalid_vs_queue", {63'd0, ovalid}, {63'd0, sb.size() != 0});
         if (ovalid && iready && sb.size() != 0) begin
            exp_head = sb.pop_front();
            checkOutput("elapsed_head", elapsed, exp_head);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] c, input logic [63:0] cnt);
      bit acc;
      ivalid  = 1'b1;
      cmd     = c;
      counter = cnt;
      acc     = sb.size() < DEPTH;
      checkOutput("oready", {63'd0, oready}, {63'd0, acc});
      tick();
      ivalid = 1'b0;
      if (acc) begin
         case (c)
            START: begin
               m_t0  = cnt;
               m_run = 1'b1;
            end
            STOP: begin
               if (m_run) sb.push_back(cnt - m_t0);
               m_run = 1'b0;
            end
            LAP: begin
               if (m_run) begin
                  sb.push_back(cnt - m_t0);
                  m_t0 = cnt;
               end
            end
            default: begin
               sb.delete();
               m_run = 1'b0;
            end
         endcase
      end
      checkOutput("running", {63'd0, running}, {63'd0, m_run});
   endtask

   task automatic doReset();
      mon_en = 1'b0;
      reset  = 1'b1;
      ivalid = 1'b0;
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      sb.delete();
      m_run  = 1'b0;
      m_t0   = '0;
      mon_en = 1'b1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_ovalid"},  {63'd0, ovalid},  64'd0);
      checkOutput({tag, "_running"}, {63'd0, running}, 64'd0);
      checkOutput({tag, "_oready"},  {63'd0, oready},  64'd1);
      checkOutput({tag, "_elapsed"}, elapsed,          64'd0);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) tick();
      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("[TB] FAIL drain: observed=%0d left expected=0", sb.size());
      end
   endtask

   initial begin
      reset   = 1'b1;
      ivalid  = 1'b0;
      cmd     = START;
      counter = '0;
      iready  = 1'b1;
      doReset();
      checkResetState("reset");

      // Basic START/STOP with one-cycle result latency.
      applyStimulus(START, 64'd100);
      applyStimulus(STOP,  64'd350);
      checkOutput("stop_ovalid",  {63'd0, ovalid}, 64'd1);
      checkOutput("stop_elapsed", elapsed, 64'd250);
      tick();
      checkOutput("stop_ovalid_after", {63'd0, ovalid}, 64'd0);

      // Laps.
      applyStimulus(START, 64'd1000);
      applyStimulus(LAP,   64'd1010);
      applyStimulus(LAP,   64'd1025);
      applyStimulus(STOP,  64'd1100);
      drain(10);

      // Counter wrap-around.
      applyStimulus(START, 64'hFFFF_FFFF_FFFF_FFF0);
      applyStimulus(STOP,  64'h10);
      checkOutput("wrap_elapsed", elapsed, 64'h20);
      drain(10);

      // Backpressure: fifth LAP must be refused while full.
      iready = 1'b0;
      applyStimulus(START, 64'd2000);
      applyStimulus(LAP,   64'd2003);
      applyStimulus(LAP,   64'd2010);
      applyStimulus(LAP,   64'd2030);
      applyStimulus(LAP,   64'd2070);
      applyStimulus(LAP,   64'd2150);
      checkOutput("full_oready", {63'd0, oready}, 64'd0);
      checkOutput("full_head_stable", elapsed, 64'd3);
      iready = 1'b1;
      drain(20);
      checkOutput("drained_oready", {63'd0, oready}, 64'd1);
      applyStimulus(STOP, 64'd2100);
      drain(10);

      // STOP in IDLE, then restart.
      applyStimulus(STOP, 64'd77);
      checkOutput("idle_stop_ovalid", {63'd0, ovalid}, 64'd0);
      applyStimulus(START, 64'd10);
      applyStimulus(START, 64'd40);
      applyStimulus(STOP,  64'd50);
      checkOutput("restart_elapsed", elapsed, 64'd10);
      drain(10);

      // CLEAR while running with two results queued, pop coinciding.
      iready = 1'b0;
      applyStimulus(START, 64'd0);
      applyStimulus(LAP,   64'd5);
      applyStimulus(LAP,   64'd9);
      iready = 1'b1;
      applyStimulus(CLEAR, 64'd20);
      checkOutput("clear_ovalid",  {63'd0, ovalid},  64'd0);
      checkOutput("clear_running", {63'd0, running}, 64'd0);
      tick();

      // Reset mid-run discards results and t0.
      iready = 1'b0;
      applyStimulus(START, 64'd1000);
      applyStimulus(LAP,   64'd1003);
      applyStimulus(LAP,   64'd1007);
      doReset();
      checkResetState("midreset");
      iready = 1'b1;
      applyStimulus(STOP,  64'd900);
      checkOutput("post_reset_idle_stop", {63'd0, ovalid}, 64'd0);
      applyStimulus(START, 64'd500);
      applyStimulus(STOP,  64'd600);
      drain(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
